// File: rtl/network_pkg.sv
// network_pkg: shared types and helpers for the sample-rate I/O path of the
// cached dilated-causal-conv network.
// Contents: default element width W, sample_t, io_state_t FSM encoding, and
// sat_shl (saturating arithmetic left shift to a signed width).
package network_pkg;

  localparam int W = 16;

  typedef logic signed [W-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } io_state_t;

  // Shift a sign-extended value left by sh and clamp it to a signed w-bit
  // range. The 64-bit working width holds any w+sh that is used here, so
  // the shift itself never loses bits before the clamp.
  function automatic logic signed [63:0] sat_shl(input logic signed [63:0] x,
                                                 input int                 sh,
                                                 input int                 w);
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    y  = x <<< sh;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (y > hi) begin
      sat_shl = hi;
    end else if (y < lo) begin
      sat_shl = lo;
    end else begin
      sat_shl = y;
    end
  endfunction

endpackage

// File: rtl/tap_history.sv
// tap_history: TAPS-deep shift register for one channel; on push every tap
// moves one place toward tap 0 and inp enters tap TAPS-1.
// Ports: sample_clk, rst (async, active-high), push, inp[W], taps_out
// (TAPS*W, tap 0 = oldest in the MSBs).
module tap_history
  import network_pkg::*;
#(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input  logic              sample_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W-1:0]      inp,
  output logic [TAPS*W-1:0] taps_out
);

  logic [W-1:0] r_taps [TAPS];

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) begin
        r_taps[t] <= '0;
      end
    end else if (push) begin
      for (int t = 0; t < TAPS - 1; t++) begin
        r_taps[t] <= r_taps[t+1];
      end
      r_taps[TAPS-1] <= inp;
    end
  end

  for (genvar t = 0; t < TAPS; t++) begin : g_out
    assign taps_out[(TAPS-1-t)*W +: W] = r_taps[t];
  end

endmodule

// File: rtl/sample_io_sequencer.sv
// sample_io_sequencer: per-sample conditioning, causal history, launch of one
// forward pass per sample, saturating post-shift of the result, overrun count.
// Ports: sample_in/net_result/sample_out are N_CH*W packed (ch0 in MSBs);
// window is TAPS*N_CH*W (tap 0 in MSBs); start/busy/net_done handshake with
// the core; overrun_count saturates, pass_count wraps.
module sample_io_sequencer
  import network_pkg::*;
#(
  parameter int              W         = 16,
  parameter int              N_CH      = 4,
  parameter int              TAPS      = 4,
  parameter int              IN_SHIFT  = 0,
  parameter int              OUT_SHIFT = 0,
  parameter logic [N_CH-1:0] CH_MASK   = {N_CH{1'b1}}
) (
  input  logic                   sample_clk,
  input  logic                   rst,
  input  logic [N_CH*W-1:0]      sample_in,
  input  logic                   bypass,
  output logic [TAPS*N_CH*W-1:0] window,
  output logic                   start,
  output logic                   busy,
  input  logic                   net_done,
  input  logic [N_CH*W-1:0]      net_result,
  output logic [N_CH*W-1:0]      sample_out,
  output logic [15:0]            overrun_count,
  output logic [15:0]            pass_count
);

  io_state_t r_state;
  io_state_t w_state_nxt;

  logic              r_start;
  logic [N_CH*W-1:0] r_sample_out;
  logic [15:0]       r_overrun;
  logic [15:0]       r_pass;

  logic w_push;
  logic w_start_nxt;
  logic w_latch_res;
  logic w_latch_byp;
  logic w_pass_inc;
  logic w_ovr_inc;

  logic [W-1:0]      w_cond    [N_CH];
  logic [TAPS*W-1:0] w_hist    [N_CH];
  logic [N_CH*W-1:0] w_res_sat;
  logic [N_CH*W-1:0] w_byp_sat;

  // Conditioning, saturated outputs and per-channel history.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [W-1:0] w_in;
    logic [W-1:0] w_res;

    assign w_in  = sample_in[(N_CH-1-ch)*W +: W];
    assign w_res = net_result[(N_CH-1-ch)*W +: W];

    assign w_cond[ch] = CH_MASK[ch] ? W'($signed(w_in) >>> IN_SHIFT) : '0;

    assign w_res_sat[(N_CH-1-ch)*W +: W] =
      W'(sat_shl({{(64-W){w_res[W-1]}}, w_res}, OUT_SHIFT, W));
    assign w_byp_sat[(N_CH-1-ch)*W +: W] =
      W'(sat_shl({{(64-W){w_cond[ch][W-1]}}, w_cond[ch]}, OUT_SHIFT, W));

    tap_history #(
      .W    (W),
      .TAPS (TAPS)
    ) u_hist (
      .sample_clk (sample_clk),
      .rst        (rst),
      .push       (w_push),
      .inp        (w_cond[ch]),
      .taps_out   (w_hist[ch])
    );

    // Re-pack from channel-major history into the tap-major window.
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign window[(TAPS-1-t)*N_CH*W + (N_CH-1-ch)*W +: W] =
        w_hist[ch][(TAPS-1-t)*W +: W];
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bypass overrides the pass sequencing: it never pushes or launches, and a
  // finished-but-unconsumed result is thrown away by returning to IDLE. A
  // pass still in flight keeps the FSM in BUSY so its completion is tracked.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_start_nxt = 1'b0;
    w_latch_res = 1'b0;
    w_latch_byp = 1'b0;
    w_pass_inc  = 1'b0;
    w_ovr_inc   = 1'b0;
    if (bypass) begin
      w_latch_byp = 1'b1;
      if (r_state == BUSY && net_done) begin
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_push      = 1'b1;
          w_start_nxt = 1'b1;
          w_state_nxt = BUSY;
        end
        BUSY: begin
          if (net_done) begin
            w_latch_res = 1'b1;
            w_pass_inc  = 1'b1;
            w_push      = 1'b1;
            w_start_nxt = 1'b1;
          end else begin
            w_ovr_inc = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      r_start      <= 1'b0;
      r_sample_out <= '0;
      r_overrun    <= '0;
      r_pass       <= '0;
    end else begin
      r_start <= w_start_nxt;
      if (w_latch_res) begin
        r_sample_out <= w_res_sat;
      end else if (w_latch_byp) begin
        r_sample_out <= w_byp_sat;
      end
      if (w_pass_inc) begin
        r_pass <= r_pass + 16'd1;
      end
      if (w_ovr_inc && r_overrun != 16'hFFFF) begin
        r_overrun <= r_overrun + 16'd1;
      end
    end
  end

  assign start         = r_start;
  assign busy          = (r_state == BUSY) && !net_done;
  assign sample_out    = r_sample_out;
  assign overrun_count = r_overrun;
  assign pass_count    = r_pass;

endmodule

// File: tb/tb_sample_io_sequencer.sv
// Scoreboard bench for sample_io_sequencer: the driver updates a behavioural
// model per sample and queues the expected post-edge outputs; a monitor pops
// and compares after every rising edge.
module tb_sample_io_sequencer;

  localparam int W         = 16;
  localparam int N_CH      = 4;
  localparam int TAPS      = 4;
  localparam int IN_SHIFT  = 2;
  localparam int OUT_SHIFT = 2;
  localparam logic [N_CH-1:0] MASK = 4'b0111;
  localparam int WW        = TAPS * N_CH * W;

  logic                   sample_clk = 1'b0;
  logic                   rst;
  logic [N_CH*W-1:0]      sample_in;
  logic                   bypass;
  logic [WW-1:0]          window;
  logic                   start;
  logic                   busy;
  logic                   net_done;
  logic [N_CH*W-1:0]      net_result;
  logic [N_CH*W-1:0]      sample_out;
  logic [15:0]            overrun_count;
  logic [15:0]            pass_count;

  sample_io_sequencer #(
    .W         (W),
    .N_CH      (N_CH),
    .TAPS      (TAPS),
    .IN_SHIFT  (IN_SHIFT),
    .OUT_SHIFT (OUT_SHIFT),
    .CH_MASK   (MASK)
  ) dut (
    .sample_clk    (sample_clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .bypass        (bypass),
    .window        (window),
    .start         (start),
    .busy          (busy),
    .net_done      (net_done),
    .net_result    (net_result),
    .sample_out    (sample_out),
    .overrun_count (overrun_count),
    .pass_count    (pass_count)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct {
    logic [WW-1:0]     win;
    logic              st;
    logic              bz;
    logic [N_CH*W-1:0] so;
    logic [15:0]       ovr;
    logic [15:0]       pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;

  // Reference model: history as a table of integers, tap 0 oldest.
  int m_hist [TAPS][N_CH];
  int m_out  [N_CH];
  bit m_busy;
  bit m_start;
  int m_ovr;
  int m_pass;

  int s_in  [N_CH];
  int s_res [N_CH];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int satf(input int x);
    int v;
    v = x * (1 << OUT_SHIFT);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [N_CH*W-1:0] pack(input int a[N_CH]);
    logic [N_CH*W-1:0] r;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      r[(N_CH-1-ch)*W +: W] = W'(a[ch]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < TAPS; t++)
      for (int ch = 0; ch < N_CH; ch++) m_hist[t][ch] = 0;
    for (int ch = 0; ch < N_CH; ch++) m_out[ch] = 0;
    m_busy  = 0;
    m_start = 0;
    m_ovr   = 0;
    m_pass  = 0;
  endtask

  // Drive one sample period (called at a falling edge), advance the model to
  // what the next rising edge should produce, queue it, wait for the next
  // falling edge.
  task automatic step(input bit byp, input bit done);
    int   c [N_CH];
    bit   push;
    exp_t e;
    sample_in  = pack(s_in);
    net_result = pack(s_res);
    bypass     = byp;
    net_done   = done;
    for (int ch = 0; ch < N_CH; ch++) c[ch] = MASK[ch] ? (s_in[ch] >>> IN_SHIFT) : 0;
    push    = 0;
    m_start = 0;
    if (byp) begin
      for (int ch = 0; ch < N_CH; ch++) m_out[ch] = satf(c[ch]);
      if (m_busy && done) m_busy = 0;
    end else if (!m_busy) begin
      push = 1; m_start = 1; m_busy = 1;
    end else if (done) begin
      for (int ch = 0; ch < N_CH; ch++) m_out[ch] = satf(s_res[ch]);
      m_pass  = (m_pass + 1) % 65536;
      push    = 1;
      m_start = 1;
    end else if (m_ovr < 65535) begin
      m_ovr++;
    end
    if (push) begin
      for (int t = 0; t < TAPS - 1; t++)
        for (int ch = 0; ch < N_CH; ch++) m_hist[t][ch] = m_hist[t+1][ch];
      for (int ch = 0; ch < N_CH; ch++) m_hist[TAPS-1][ch] = c[ch];
    end
    e.win = '0;
    for (int t = 0; t < TAPS; t++)
      for (int ch = 0; ch < N_CH; ch++)
        e.win[(TAPS-1-t)*N_CH*W + (N_CH-1-ch)*W +: W] = W'(m_hist[t][ch]);
    e.st  = m_start;
    e.bz  = m_busy && !done;
    e.so  = pack(m_out);
    e.ovr = 16'(m_ovr);
    e.pc  = 16'(m_pass);
    sb.push_back(e);
    @(negedge sample_clk);
  endtask

  function automatic int rnd16();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic rand_io();
    for (int ch = 0; ch < N_CH; ch++) begin
      s_in[ch]  = rnd16();
      s_res[ch] = rnd16();
    end
  endtask

  always @(posedge sample_clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("window",        window,        mon_e.win);
      chk("start",         start,         mon_e.st);
      chk("busy",          busy,          mon_e.bz);
      chk("sample_out",    sample_out,    mon_e.so);
      chk("overrun_count", overrun_count, mon_e.ovr);
      chk("pass_count",    pass_count,    mon_e.pc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bypass     = 1'b0;
    net_done   = 1'b0;
    sample_in  = '0;
    net_result = '0;
    model_reset();
    repeat (2) @(negedge sample_clk);
    chk("rst_window", window, '0);
    chk("rst_start", start, '0);
    chk("rst_busy", busy, '0);
    chk("rst_sample_out", sample_out, '0);
    chk("rst_overrun", overrun_count, '0);
    chk("rst_pass", pass_count, '0);
    rst = 1'b0;

    // ch0 = 4,8,12,16 pre-shifted by 2 gives history 1,2,3,4.
    for (int k = 1; k <= 4; k++) begin
      rand_io();
      s_in[0] = 4 * k;
      step(0, 1);
    end
    for (int t = 0; t < TAPS; t++)
      chk("hist_ch0", window[(TAPS-1-t)*N_CH*W + (N_CH-1)*W +: W], WW'(t + 1));
    chk("pass_after_4", pass_count, 3);

    // Shift and mask: ch3 disabled.
    s_in[0] = -8; s_in[1] = 16; s_in[2] = 7; s_in[3] = 100;
    step(0, 1);
    chk("cond_entry", window[N_CH*W-1:0], {16'hFFFE, 16'd4, 16'd1, 16'd0});

    // Saturating post-shift.
    s_res[0] = 'h3000;  step(0, 1);
    chk("sat_pos", sample_out[N_CH*W-1 -: W], 16'h7FFF);
    s_res[0] = -'h3000; step(0, 1);
    chk("sat_neg", sample_out[N_CH*W-1 -: W], 16'h8000);
    s_res[0] = 5;       step(0, 1);
    chk("sat_small", sample_out[N_CH*W-1 -: W], 16'd20);

    // Three overruns, then completion.
    for (int k = 0; k < 3; k++) begin rand_io(); step(0, 0); end
    chk("overrun_3", overrun_count, 3);
    rand_io(); step(0, 1);

    // Bypass while BUSY with a result pending, then release.
    rand_io(); step(1, 1);
    rand_io(); step(0, 1);

    // Reset one cycle after start; a late net_done must not latch.
    rand_io(); step(0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_window", window, '0);
    chk("mid_rst_start", start, '0);
    chk("mid_rst_out", sample_out, '0);
    chk("mid_rst_pass", pass_count, '0);
    net_done = 1'b1;
    rand_io();
    net_result = pack(s_res);
    @(negedge sample_clk);
    chk("rst_no_latch", sample_out, '0);
    chk("rst_busy_low", busy, '0);
    rst = 1'b0;
    model_reset();
    rand_io(); step(0, 1);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      rand_io();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end

    @(posedge sample_clk);
    #3;
    chk("sb_drain", WW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_io_sequencer.md
# sample_io_sequencer

Sample-rate front/back end for the cached dilated-causal-conv network, clocked on `sample_clk`. It performs these steps each sample period:
- conditions N_CH input channels (per-channel enable, arithmetic pre-shift) and keeps a TAPS-deep causal history per channel;
- launches one forward pass of the compute core and collects its result;
- post-shifts the result with saturation and drives the output channels.

It also detects and counts overruns, where a new sample arrives before the previous pass finished.

## Interface
Parameters:
- `W`, 16, sample/element width, signed two's complement
- `N_CH`, 4, channel count for both inputs and outputs
- `TAPS`, 4, history depth per channel; this is the kernel size of the first conv
- `IN_SHIFT`, 0, arithmetic right shift applied to inputs (0 for sim, 2 for eurorack pmod)
- `OUT_SHIFT`, 0, saturating left shift applied to results
- `CH_MASK`, {N_CH{1'b1}}, per-channel enable; a disabled channel feeds 0 into history

Ports:
- `sample_clk`  in  1  sample-rate clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `sample_in`  in  N_CH*W  packed inputs, channel 0 in MSBs
- `bypass`  in  1  1: outputs follow conditioned inputs and no passes are launched
- `window`  out  TAPS*N_CH*W  packed history; tap 0 (oldest) in MSBs, each tap N_CH channels in ch0-MSB order
- `start`  out  1  one-cycle pulse requesting a forward pass over `window`
- `busy`  out  1  a pass is outstanding
- `net_done`  in  1  level from the core, already synchronous to `sample_clk`; high = result valid, held until next `start`
- `net_result`  in  N_CH*W  packed core output, ch0 in MSBs
- `sample_out`  out  N_CH*W  packed outputs, ch0 in MSBs
- `overrun_count`  out  16  dropped-sample count, saturating at 16'hFFFF
- `pass_count`  out  16  completed passes, wrapping

## Operation
- Conditioning: `c[i] = CH_MASK[i] ? (sample_in[i] >>> IN_SHIFT) : 0`.
- History push: taps shift one place toward tap 0, and `c` enters tap TAPS-1. The history is only updated on a push.
- FSM states:
  - IDLE is entered from reset. On the next edge with bypass=0: push, pulse `start`, go to BUSY.
  - BUSY with `net_done`=1 at an edge:
    - latch `sat(net_result[i] <<< OUT_SHIFT)` into `sample_out`;
    - increment `pass_count`;
    - push the new sample;
    - pulse `start`;
    - stay in BUSY.
  - BUSY with `net_done`=0 at an edge (overrun):
    - the sample is dropped, with no push and no `start`;
    - `overrun_count` increments (saturating);
    - `sample_out` holds;
    - the state stays BUSY.
  - bypass=1 at any edge:
    - `sample_out[i] = sat(c[i] <<< OUT_SHIFT)`;
    - no push and no start;
    - if BUSY with `net_done`=1, the pending result is discarded and the state goes to IDLE;
    - if BUSY with `net_done`=0, the state stays BUSY and no overrun is counted.
- `sat(x)`: compute at W+OUT_SHIFT bits, then clamp to [-2^(W-1), 2^(W-1)-1].
- `busy` = (state == BUSY) && !net_done.

## Timing
- Reset values: `window`=0, `start`=0, `busy`=0, `sample_out`=0, `overrun_count`=0, `pass_count`=0, state=IDLE.
- Sample captured at edge n:
  - is visible in `window` tap TAPS-1 after edge n;
  - `start` is high for cycle n→n+1;
  - its result appears on `sample_out` after edge n+1, provided `net_done` is high at that edge.
- Total latency is one sample period; the core must finish within one `sample_clk` period.
- `window` is stable from a `start` until the next push.
- `rst` asserted mid-pass returns the block to IDLE and zeroes all outputs immediately. A late `net_done` is ignored until the next `start`.
- Change of `bypass` takes effect at the next edge. There is no glitch on `sample_out` other than the value update.

## Structure
- Shared package `network_pkg`:
  - `W` default;
  - `sample_t` typedef (`logic signed [W-1:0]`);
  - `sat_shl` function (saturating left shift);
  - FSM state enum `io_state_t` {IDLE, BUSY}.
- Sub-module `tap_history` (W, TAPS; push, inp, packed out, async rst), instantiated once per channel via generate. It generalises the existing 4-tap left shift buffer.

## Test plan
- Reset, then samples ch0 = 1, 2, 3, 4 with `net_done` tied 1 and W=16, TAPS=4 → after 4th edge window ch0 taps = 1, 2, 3, 4 (tap 0 = 1); `start` pulses each edge; `pass_count`=3.
- IN_SHIFT=2, CH_MASK=4'b0111, in = {-8, 16, 7, 100} → history entry {-2, 4, 1, 0}.
- OUT_SHIFT=2, `net_result` ch0 = 16'h3000 → `sample_out` ch0 = 16'h7FFF; ch0 = -16'h3000 → 16'h8000; ch0 = 5 → 20.
- Hold `net_done`=0 for 3 edges after a `start` → `overrun_count`=3, `window` unchanged, `sample_out` holds, no `start`. Raise `net_done` → result latched, one `start`.
- `bypass`=1 while BUSY with `net_done`=1 → `sample_out` = conditioned input next edge, state IDLE, `start` low. Drop `bypass` → `start` on next edge.
- Assert `rst` one cycle after `start` → all outputs 0 immediately; a following `net_done`=1 causes no latch; the next edge after release pulses `start`.
